// File: rtl/ro_frame_sequencer_pkg.sv
// Shared types and defaults for the readout sequencer family.
// Holds the FSM state encoding and the index-width helper used by the top and interface.
package ro_frame_sequencer_pkg;

  typedef enum logic {
    RO_IDLE = 1'b0,
    RO_SEND = 1'b1
  } ro_state_e;

  localparam int RO_N_CH_DEF = 8;
  localparam int RO_W_DEF    = 2;

  // Index width that stays legal (>=1 bit) for single-entry ranges.
  function automatic int ro_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_frame_sequencer_if.sv
// Channel-bank side and pad side of the readout sequencer, bundled as one port.
// master drives the frame controls and channel words; slave is the sequencer.
interface ro_frame_sequencer_if
  import ro_frame_sequencer_pkg::*;
#(
  parameter int N_CH = RO_N_CH_DEF,
  parameter int W    = RO_W_DEF
);
  localparam int CH_W = ro_idx_w(N_CH);

  logic              clk_64;
  logic              en;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH*W-1:0] ch_data;
  logic              clr_ovr;
  logic [W-1:0]      out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_en;
  logic              out_sof;
  logic              busy;
  logic              overrun;

  modport master (
    output clk_64, en, ch_mask, ch_data, clr_ovr,
    input  out_data, out_ch, out_en, out_sof, busy, overrun
  );

  modport slave (
    input  clk_64, en, ch_mask, ch_data, clr_ovr,
    output out_data, out_ch, out_en, out_sof, busy, overrun
  );

endinterface

// File: rtl/ro_next_ch.sv
// Combinational channel picker: lowest set bit of mask (first=1) or next set bit above cur.
// found=0 when no qualifying bit exists; nxt is then 0.
module ro_next_ch #(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  input  logic            first,
  output logic [CH_W-1:0] nxt,
  output logic            found
);

  // Scanning downwards leaves the lowest qualifying bit as the final winner.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_frame_sequencer.sv
// Frame readout sequencer: snapshots the channel bank on a clk_64 rising edge and streams
// unmasked channels one slot each; first slot appears two edges after the tick, no backpressure.
module ro_frame_sequencer
  import ro_frame_sequencer_pkg::*;
#(
  parameter int N_CH     = RO_N_CH_DEF,
  parameter int W        = RO_W_DEF,
  parameter int SLOT_CYC = 1
) (
  input  logic                 clk_ext,
  input  logic                 rstb,
  ro_frame_sequencer_if.slave  bus
);

  localparam int CH_W = ro_idx_w(N_CH);
  localparam int SC_W = ro_idx_w(SLOT_CYC);
  localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SLOT_CYC - 1);

  ro_state_e                 state;
  logic                      clk_64_d;
  logic [N_CH-1:0][W-1:0]    shadow;
  logic [N_CH-1:0]           mask_r;
  logic [CH_W-1:0]           ptr;
  logic [SC_W-1:0]           slot_cnt;
  logic                      sof_pend;

  logic                      tick;
  logic [N_CH-1:0]           pick_mask;
  logic                      pick_first;
  logic [CH_W-1:0]           pick_nxt;
  logic                      pick_found;

  assign tick = bus.clk_64 & ~clk_64_d;

  // In IDLE the picker looks at the live mask to find the frame's first channel;
  // in SEND it walks the snapshot upwards from the current pointer.
  assign pick_first = (state == RO_IDLE);
  assign pick_mask  = pick_first ? bus.ch_mask : mask_r;

  ro_next_ch #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_next_ch (
    .mask  (pick_mask),
    .cur   (ptr),
    .first (pick_first),
    .nxt   (pick_nxt),
    .found (pick_found)
  );

  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      state        <= RO_IDLE;
      clk_64_d     <= 1'b1;
      shadow       <= '0;
      mask_r       <= '0;
      ptr          <= '0;
      slot_cnt     <= '0;
      sof_pend     <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.out_en   <= 1'b0;
      bus.out_sof  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      clk_64_d <= bus.clk_64;

      // A new set outranks a clear arriving on the same edge.
      if (tick && (state == RO_SEND)) begin
        bus.overrun <= 1'b1;
      end else if (bus.clr_ovr) begin
        bus.overrun <= 1'b0;
      end

      if (!bus.en) begin
        state        <= RO_IDLE;
        slot_cnt     <= '0;
        sof_pend     <= 1'b0;
        bus.out_data <= '0;
        bus.out_ch   <= '0;
        bus.out_en   <= 1'b0;
        bus.out_sof  <= 1'b0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          RO_IDLE: begin
            bus.out_data <= '0;
            bus.out_ch   <= '0;
            bus.out_en   <= 1'b0;
            bus.out_sof  <= 1'b0;
            bus.busy     <= 1'b0;
            if (tick && pick_found) begin
              shadow   <= bus.ch_data;
              mask_r   <= bus.ch_mask;
              ptr      <= pick_nxt;
              slot_cnt <= '0;
              sof_pend <= 1'b1;
              state    <= RO_SEND;
            end
          end
          RO_SEND: begin
            bus.out_data <= shadow[ptr];
            bus.out_ch   <= ptr;
            bus.out_en   <= 1'b1;
            bus.busy     <= 1'b1;
            bus.out_sof  <= sof_pend;
            if (slot_cnt == SLOT_LAST) begin
              slot_cnt <= '0;
              sof_pend <= 1'b0;
              if (pick_found) begin
                ptr <= pick_nxt;
              end else begin
                state <= RO_IDLE;
              end
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
          default: state <= RO_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_frame_sequencer.sv
// Bench for ro_frame_sequencer: two instances (SLOT_CYC 1 and 4) share one stimulus stream;
// a frame-level reference model queues expected slots and a negedge monitor scores them.
module tb_ro_frame_sequencer;

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] dat;
    logic       sof;
  } slot_t;

  logic        clk_ext;
  logic        rstb;
  logic        clk_64;
  logic        en;
  logic [7:0]  ch_mask;
  logic [15:0] ch_data;
  logic        clr_ovr;

  ro_frame_sequencer_if #(.N_CH(8), .W(2)) if1 ();
  ro_frame_sequencer_if #(.N_CH(8), .W(2)) if4 ();

  assign if1.clk_64  = clk_64;
  assign if1.en      = en;
  assign if1.ch_mask = ch_mask;
  assign if1.ch_data = ch_data;
  assign if1.clr_ovr = clr_ovr;
  assign if4.clk_64  = clk_64;
  assign if4.en      = en;
  assign if4.ch_mask = ch_mask;
  assign if4.ch_data = ch_data;
  assign if4.clr_ovr = clr_ovr;

  ro_frame_sequencer #(.N_CH(8), .W(2), .SLOT_CYC(1)) dut1 (
    .clk_ext (clk_ext),
    .rstb    (rstb),
    .bus     (if1)
  );

  ro_frame_sequencer #(.N_CH(8), .W(2), .SLOT_CYC(4)) dut4 (
    .clk_ext (clk_ext),
    .rstb    (rstb),
    .bus     (if4)
  );

  logic       o_en   [2];
  logic       o_busy [2];
  logic       o_ovr  [2];
  logic       o_sof  [2];
  logic [2:0] o_ch   [2];
  logic [1:0] o_dat  [2];

  assign o_en[0]   = if1.out_en;
  assign o_busy[0] = if1.busy;
  assign o_ovr[0]  = if1.overrun;
  assign o_sof[0]  = if1.out_sof;
  assign o_ch[0]   = if1.out_ch;
  assign o_dat[0]  = if1.out_data;
  assign o_en[1]   = if4.out_en;
  assign o_busy[1] = if4.busy;
  assign o_ovr[1]  = if4.overrun;
  assign o_sof[1]  = if4.out_sof;
  assign o_ch[1]   = if4.out_ch;
  assign o_dat[1]  = if4.out_data;

  // Reference model state, one entry per instance.
  slot_t exp_q [2][$];
  int    rem   [2];
  bit    act   [2];
  bit    exp_ovr [2];
  bit    prev64;
  bit    mon_on;

  int n_chk;
  int n_fail;

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  function automatic int slot_cyc_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, idx, $time, got, exp);
    end
  endtask

  // One clock edge of the reference model, evaluated on the inputs held across that edge.
  task automatic model_edge();
    bit tick;
    bit set;
    bit first;
    slot_t s;
    if (!rstb) begin
      prev64 = 1'b1;
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        rem[i]     = 0;
        act[i]     = 1'b0;
        exp_ovr[i] = 1'b0;
      end
      return;
    end
    tick   = clk_64 & ~prev64;
    prev64 = clk_64;
    for (int i = 0; i < 2; i++) begin
      set = 1'b0;
      if (rem[i] > 0) begin
        if (tick) set = 1'b1;
        if (!en) begin
          for (int k = 0; k < rem[i]; k++) void'(exp_q[i].pop_back());
          rem[i] = 0;
          act[i] = 1'b0;
        end else begin
          act[i] = 1'b1;
          rem[i]--;
        end
      end else begin
        act[i] = 1'b0;
        if (tick && en && (ch_mask != 8'h00)) begin
          first = 1'b1;
          for (int c = 0; c < 8; c++) begin
            if (ch_mask[c]) begin
              for (int r = 0; r < slot_cyc_of(i); r++) begin
                s.ch  = 3'(c);
                s.dat = ch_data[c*2 +: 2];
                s.sof = first;
                exp_q[i].push_back(s);
                rem[i]++;
              end
              first = 1'b0;
            end
          end
        end
      end
      if (set) exp_ovr[i] = 1'b1;
      else if (clr_ovr) exp_ovr[i] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk_ext);
    model_edge();
    @(negedge clk_ext);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic tick_pulse();
    clk_64 = 1'b1;
    cyc();
    clk_64 = 1'b0;
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_out_en"},   i, 8'(o_en[i]),   8'h0);
      chk({tag, "_busy"},     i, 8'(o_busy[i]), 8'h0);
      chk({tag, "_overrun"},  i, 8'(o_ovr[i]),  8'h0);
      chk({tag, "_out_sof"},  i, 8'(o_sof[i]),  8'h0);
      chk({tag, "_out_ch"},   i, 8'(o_ch[i]),   8'h0);
      chk({tag, "_out_data"}, i, 8'(o_dat[i]),  8'h0);
    end
  endtask

  // Monitor: scores every cycle against the model, popping a slot whenever one is due.
  initial begin
    slot_t e;
    forever begin
      @(negedge clk_ext);
      if (rstb && mon_on) begin
        for (int i = 0; i < 2; i++) begin
          chk("out_en",  i, 8'(o_en[i]),   8'(act[i]));
          chk("busy",    i, 8'(o_busy[i]), 8'(act[i]));
          chk("overrun", i, 8'(o_ovr[i]),  8'(exp_ovr[i]));
          if (act[i]) begin
            if (exp_q[i].size() == 0) begin
              chk("slot_available", i, 8'h0, 8'h1);
            end else begin
              e = exp_q[i].pop_front();
              chk("out_ch",   i, 8'(o_ch[i]),  8'(e.ch));
              chk("out_data", i, 8'(o_dat[i]), 8'(e.dat));
              chk("out_sof",  i, 8'(o_sof[i]), 8'(e.sof));
            end
          end else begin
            chk("idle_out_ch",   i, 8'(o_ch[i]),  8'h0);
            chk("idle_out_data", i, 8'(o_dat[i]), 8'h0);
            chk("idle_out_sof",  i, 8'(o_sof[i]), 8'h0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    mon_on  = 1'b0;
    rstb    = 1'b0;
    clk_64  = 1'b0;
    en      = 1'b1;
    ch_mask = 8'h00;
    ch_data = 16'h0000;
    clr_ovr = 1'b0;
    cycles(3);
    chk_all_zero("reset");
    rstb   = 1'b1;
    mon_on = 1'b1;
    cycles(2);

    // Full mask, ch i carries i%4.
    for (int c = 0; c < 8; c++) ch_data[c*2 +: 2] = 2'(c % 4);
    ch_mask = 8'hFF;
    tick_pulse();
    cycles(40);

    // Sparse mask: ch2, ch5, ch7.
    ch_mask = 8'b1010_0100;
    ch_data = 16'hB4E1;
    tick_pulse();
    cycles(20);

    // Snapshot: live mask/data scrambled throughout the frame.
    ch_mask = 8'hFF;
    ch_data = 16'h1B6C;
    tick_pulse();
    for (int k = 0; k < 34; k++) begin
      ch_data = 16'($urandom);
      ch_mask = 8'($urandom);
      cyc();
    end
    ch_mask = 8'hFF;
    cycles(6);

    // clk_64 period 6 cycles: later ticks land mid-frame.
    for (int k = 0; k < 7; k++) begin
      clk_64 = 1'b1;
      cycles(3);
      clk_64 = 1'b0;
      cycles(3);
    end
    cycles(40);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    tick_pulse();
    cyc();
    clk_64  = 1'b1;
    clr_ovr = 1'b1;
    cyc();
    clk_64  = 1'b0;
    clr_ovr = 1'b0;
    cycles(40);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    cycles(2);

    // Empty mask ticks, then an abort at slot 3.
    ch_mask = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      cyc();
    end
    ch_mask = 8'hFF;
    tick_pulse();
    cycles(2);
    en = 1'b0;
    cyc();
    en = 1'b1;
    cycles(40);

    // Asynchronous reset mid-frame, released with clk_64 high.
    tick_pulse();
    cycles(3);
    #2;
    rstb = 1'b0;
    #1;
    chk_all_zero("async_reset");
    clk_64 = 1'b1;
    @(negedge clk_ext);
    cycles(2);
    rstb = 1'b1;
    cycles(5);
    clk_64 = 1'b0;
    cyc();
    tick_pulse();
    cycles(40);

    // Randomized traffic.
    for (int k = 0; k < 700; k++) begin
      en      = ($urandom_range(0, 24) != 0);
      clk_64  = ($urandom_range(0, 5) == 0) ? ~clk_64 : clk_64;
      clr_ovr = ($urandom_range(0, 9) == 0);
      ch_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ch_mask = 8'($urandom) & 8'($urandom);
      cyc();
    end
    en      = 1'b1;
    clk_64  = 1'b0;
    clr_ovr = 1'b0;
    cycles(50);

    for (int i = 0; i < 2; i++) chk("queue_drained", i, 8'(exp_q[i].size()), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
